// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
//   seg_t      - 7-bit segment vector, bit order g..a (bit 6 = g, bit 0 = a)
//   SEG_BLANK  - all segments off (active-low)
//   HEX7       - hex digit 0..F to active-low segment pattern
//   hex7()     - nibble to segment pattern lookup
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Active-low patterns, index = nibble value.
   localparam seg_t HEX7 [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   function automatic seg_t hex7(input logic [3:0] nibble);
      return HEX7[nibble];
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed N-digit hex display driver.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   disp         value to show, DIGITS nibbles, nibble 0 on dig[0]
//   ss           segments g..a, active-low, registered
//   dig          digit selects, active-low one-hot, registered
// Each digit slot lasts SCAN_DIV clocks. ss/dig are loaded once, in the first
// clock of a slot, so a display change appears from the next slot onward.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 always shows).
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   disp,
   output logic [6:0]            ss,
   output logic [DIGITS-1:0]     dig
);

   localparam int DW = 4 * DIGITS;
   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]     scan_cnt;
   logic [IW-1:0]     scan_idx;
   logic [3:0]        nibble;
   logic [DIGITS-1:0] upper_nz;   // upper_nz[k]: nibble k or any above is non-zero
   logic              blank;
   seg_t              seg_next;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_upper
         assign upper_nz[gi] = |disp[DW-1:4*gi];
      end
   endgenerate

   assign nibble = disp[4*int'(scan_idx) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
   assign blank = (scan_idx != '0) && !upper_nz[scan_idx];
`else
   assign blank = 1'b0;
`endif

   assign seg_next = blank ? SEG_BLANK : hex7(nibble);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
         ss       <= SEG_BLANK;
         dig      <= '1;
      end else begin
         if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         // First clock of a slot: index has just moved, latch select and segments.
         if (scan_cnt == '0) begin
            dig <= ~(DIGITS'(1) << scan_idx);
            ss  <= seg_next;
         end
      end
   end

endmodule

// File: rtl/seg7_fifo_viewer.sv
// seg7_fifo_viewer: data generator -> synchronous FIFO -> display register ->
// multiplexed hex 7-segment display.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   en_tick      one-clk enable; qualifies push and pop
//   gen_en       push request (level)
//   rd_en        pop request (level)
//   ss, dig      active-low segments (g..a) and digit selects
//   usedw        FIFO occupancy 0..DEPTH
//   full, empty  occupancy flags (registered)
//   drop         one-clk pulse when a push is requested while full
// Generator: GEN_MODE=0 incrementing counter, GEN_MODE=1 Galois LFSR (POLY mask).
// Build option: LEADING_ZERO_BLANK_EN (see seg7_scan).
module seg7_fifo_viewer
   import seg7_pkg::*;
#(
   parameter int          DIGITS   = 4,
   parameter int          DEPTH    = 16,
   parameter int          GEN_MODE = 0,
   parameter int unsigned POLY     = 32'h0000_B400,
   parameter int          SCAN_DIV = 50000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_tick,
   input  logic                     gen_en,
   input  logic                     rd_en,
   output logic [6:0]               ss,
   output logic [DIGITS-1:0]        dig,
   output logic [$clog2(DEPTH):0]   usedw,
   output logic                     full,
   output logic                     empty,
   output logic                     drop
);

   localparam int             DW       = 4 * DIGITS;
   localparam int             AW       = $clog2(DEPTH);
   localparam logic [DW-1:0]  POLY_W   = DW'(POLY);
   localparam logic [DW-1:0]  GEN_SEED = (GEN_MODE == 1) ? DW'(1) : '0;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   usedw_reg;
   logic [AW:0]   usedw_next;
   logic          full_reg;
   logic          empty_reg;
   logic          drop_reg;
   logic [DW-1:0] gen_reg;
   logic [DW-1:0] gen_next;
   logic [DW-1:0] disp_reg;
   logic          push;
   logic          pop;

   // A push while full stays blocked even when a pop frees a slot on the same tick.
   assign push = en_tick & gen_en & ~full_reg;
   assign pop  = en_tick & rd_en  & ~empty_reg;

   generate
      if (GEN_MODE == 1) begin : g_lfsr
         assign gen_next = gen_reg[0] ? ((gen_reg >> 1) ^ POLY_W) : (gen_reg >> 1);
      end else begin : g_count
         assign gen_next = gen_reg + 1'b1;
      end
   endgenerate

   always_comb begin
      usedw_next = usedw_reg;
      case ({push, pop})
         2'b10:   usedw_next = usedw_reg + 1'b1;
         2'b01:   usedw_next = usedw_reg - 1'b1;
         default: usedw_next = usedw_reg;
      endcase
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= gen_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         usedw_reg <= '0;
         full_reg  <= 1'b0;
         empty_reg <= 1'b1;
         drop_reg  <= 1'b0;
         gen_reg   <= GEN_SEED;
         disp_reg  <= '0;
      end else begin
         drop_reg <= en_tick & gen_en & full_reg;
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            gen_reg <= gen_next;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            disp_reg <= mem[rd_ptr];
         end
         usedw_reg <= usedw_next;
         full_reg  <= (usedw_next == (AW+1)'(DEPTH));
         empty_reg <= (usedw_next == '0);
      end
   end

   assign usedw = usedw_reg;
   assign full  = full_reg;
   assign empty = empty_reg;
   assign drop  = drop_reg;

   seg7_scan #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk   (clk),
      .rst_n (rst_n),
      .disp  (disp_reg),
      .ss    (ss),
      .dig   (dig)
   );

endmodule
